// File: rtl/ldpc_llr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ldpc_llr_buffer                                              |
// | Description : Multi-bank LLR input buffer for the LDPC decoder. Packs a    |
// |               stream of soft-decision samples into codeword banks, each    |
// |               with a run-time codeword length, and serves committed banks  |
// |               to the decoder for random-access reads until released.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ldpc_llr_buffer #(
  parameter int LLR_WIDTH  = 8,
  parameter int MAX_CW_LEN = 2304,
  parameter int NUM_BANKS  = 2,
  localparam int AW = $clog2(MAX_CW_LEN),
  localparam int LW = $clog2(MAX_CW_LEN + 1),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [LW-1:0]        i_cw_len,
  input  logic [LLR_WIDTH-1:0] i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_cw_avail,
  output logic [LW-1:0]        o_cw_len,
  input  logic                 i_rd_en,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [LLR_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_cw_release,
  output logic [BW:0]          o_occupancy,
  output logic                 o_len_err
);

  localparam int            c_depth     = NUM_BANKS * (2 ** AW);
  localparam logic [LW-1:0] c_max_len   = LW'(MAX_CW_LEN);
  localparam logic [BW:0]   c_num_banks = (BW + 1)'(NUM_BANKS);

  // Sample storage, addressed as {bank, index}; contents are never reset.
  logic [LLR_WIDTH-1:0] r_mem [c_depth];

  logic [BW-1:0]        r_wr_bank;
  logic [BW-1:0]        r_rd_bank;
  logic [AW-1:0]        r_wr_count;
  logic [LW-1:0]        r_cur_len;
  logic [LW-1:0]        r_bank_len [NUM_BANKS];
  logic [BW:0]          r_occupancy;
  logic                 r_in_ready;
  logic                 r_len_err;
  logic                 r_rd_valid;
  logic [LLR_WIDTH-1:0] r_rd_data;

  logic                 w_wr;
  logic                 w_first;
  logic                 w_len_bad;
  logic [LW-1:0]        w_len_sel;
  logic [LW-1:0]        w_eff_len;
  logic                 w_commit;
  logic                 w_cw_avail;
  logic                 w_release;
  logic [LW-1:0]        w_cw_len;
  logic                 w_rd_ok;
  logic [BW:0]          w_occ_next;

  // Write-side decode: the length is taken live on the first sample so that
  // a one-sample codeword can commit on the very sample that sets its length.
  always_comb begin
    w_wr      = i_in_valid && r_in_ready;
    w_first   = (r_wr_count == '0);
    w_len_bad = (i_cw_len == '0) || (i_cw_len > c_max_len);
    w_len_sel = w_len_bad ? c_max_len : i_cw_len;
    w_eff_len = w_first ? w_len_sel : r_cur_len;
    w_commit  = w_wr && (LW'(r_wr_count) == (w_eff_len - LW'(1)));
  end

  // Read-side decode: reads are gated to the committed length of the read bank.
  always_comb begin
    w_cw_avail = (r_occupancy != '0);
    w_release  = i_cw_release && w_cw_avail;
    w_cw_len   = w_cw_avail ? r_bank_len[r_rd_bank] : '0;
    w_rd_ok    = i_rd_en && w_cw_avail && (LW'(i_rd_addr) < w_cw_len);
  end

  // Occupancy next value: a commit and a release in the same cycle cancel.
  always_comb begin
    w_occ_next = r_occupancy;
    if (w_commit && !w_release) begin
      w_occ_next = r_occupancy + (BW + 1)'(1);
    end else if (!w_commit && w_release) begin
      w_occ_next = r_occupancy - (BW + 1)'(1);
    end
  end

  // Sample RAM write port.
  always_ff @(posedge i_clock) begin
    if (w_wr) begin
      r_mem[{r_wr_bank, r_wr_count}] <= i_in_data;
    end
  end

  // Write pointer, codeword length tracking and bank commit.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_bank  <= '0;
      r_wr_count <= '0;
      r_cur_len  <= '0;
      r_len_err  <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_bank_len[b] <= '0;
      end
    end else begin
      r_len_err <= w_wr && w_first && w_len_bad;
      if (w_wr && w_first) begin
        r_cur_len <= w_len_sel;
      end
      if (w_commit) begin
        r_bank_len[r_wr_bank] <= w_eff_len;
        r_wr_bank             <= r_wr_bank + BW'(1);
        r_wr_count            <= '0;
      end else if (w_wr) begin
        r_wr_count <= r_wr_count + AW'(1);
      end
    end
  end

  // Read pointer, occupancy and registered input-ready.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_bank   <= '0;
      r_occupancy <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      if (w_release) begin
        r_rd_bank <= r_rd_bank + BW'(1);
      end
      r_occupancy <= w_occ_next;
      r_in_ready  <= (w_occ_next < c_num_banks);
    end
  end

  // Registered read port; the read uses the bank selected before any release.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[{r_rd_bank, i_rd_addr}];
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_cw_avail  = w_cw_avail;
  assign o_cw_len    = w_cw_len;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_occupancy = r_occupancy;
  assign o_len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_llr_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ldpc_llr_buffer                                           |
// | Description : Directed self-checking bench for ldpc_llr_buffer.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ldpc_llr_buffer;

  localparam int LLR_WIDTH  = 8;
  localparam int MAX_CW_LEN = 2304;
  localparam int NUM_BANKS  = 2;
  localparam int AW = $clog2(MAX_CW_LEN);
  localparam int LW = $clog2(MAX_CW_LEN + 1);
  localparam int BW = $clog2(NUM_BANKS);

  logic                 i_clock = 1'b0;
  logic                 i_reset_n;
  logic [LW-1:0]        i_cw_len;
  logic [LLR_WIDTH-1:0] i_in_data;
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic                 o_cw_avail;
  logic [LW-1:0]        o_cw_len;
  logic                 i_rd_en;
  logic [AW-1:0]        i_rd_addr;
  logic [LLR_WIDTH-1:0] o_rd_data;
  logic                 o_rd_valid;
  logic                 i_cw_release;
  logic [BW:0]          o_occupancy;
  logic                 o_len_err;

  int n_checks = 0;
  int n_errors = 0;
  int len_err_cnt = 0;

  ldpc_llr_buffer #(
    .LLR_WIDTH (LLR_WIDTH),
    .MAX_CW_LEN(MAX_CW_LEN),
    .NUM_BANKS (NUM_BANKS)
  ) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_cw_len    (i_cw_len),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_cw_avail  (o_cw_avail),
    .o_cw_len    (o_cw_len),
    .i_rd_en     (i_rd_en),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .i_cw_release(i_cw_release),
    .o_occupancy (o_occupancy),
    .o_len_err   (o_len_err)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
    if (o_len_err === 1'b1) len_err_cnt++;
  endtask

  // Stream n samples with data (base+i) mod 256, optionally releasing on the last one.
  task automatic send_cw(input int len, input int n, input int base, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      i_in_valid   = 1'b1;
      i_in_data    = LLR_WIDTH'(base + i);
      i_cw_len     = LW'(len);
      i_cw_release = rel_last && (i == n - 1);
      guard = 0;
      while (o_in_ready !== 1'b1 && guard < 1000) begin
        tick();
        guard++;
      end
      if (guard >= 1000) begin
        chk("in_ready_timeout", 32'(o_in_ready), 32'd1);
        break;
      end
      tick();
    end
    i_in_valid   = 1'b0;
    i_cw_release = 1'b0;
  endtask

  task automatic rd(input string tag, input int addr, input bit exp_valid, input int exp_data);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(addr);
    tick();
    i_rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(o_rd_valid), 32'(exp_valid));
    if (exp_valid) chk({tag, "_data"}, 32'(o_rd_data), 32'(exp_data));
  endtask

  task automatic release_pulse();
    i_cw_release = 1'b1;
    tick();
    i_cw_release = 1'b0;
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_cw_len     = '0;
    i_in_data    = '0;
    i_in_valid   = 1'b0;
    i_rd_en      = 1'b0;
    i_rd_addr    = '0;
    i_cw_release = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_cw_avail", 32'(o_cw_avail), 32'd0);
    chk("rst_cw_len", 32'(o_cw_len), 32'd0);
    chk("rst_occ", 32'(o_occupancy), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_len_err", 32'(o_len_err), 32'd0);
    i_reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(o_in_ready), 32'd1);

    // Full-length codeword into bank 0
    len_err_cnt = 0;
    send_cw(2304, 2304, 0, 1'b0);
    chk("cw1_avail", 32'(o_cw_avail), 32'd1);
    chk("cw1_len", 32'(o_cw_len), 32'd2304);
    chk("cw1_occ", 32'(o_occupancy), 32'd1);
    chk("cw1_ready", 32'(o_in_ready), 32'd1);
    chk("cw1_no_len_err", 32'(len_err_cnt), 32'd0);
    rd("cw1_rd0", 0, 1'b1, 8'h00);
    rd("cw1_rd1", 1, 1'b1, 8'h01);
    rd("cw1_rd2303", 2303, 1'b1, 8'hFF);
    rd("cw1_rd2304", 2304, 1'b0, 0);

    // Release to empty: read bank moves to 1
    release_pulse();
    chk("rel1_occ", 32'(o_occupancy), 32'd0);
    chk("rel1_avail", 32'(o_cw_avail), 32'd0);
    chk("rel1_len", 32'(o_cw_len), 32'd0);

    // Two codewords fill both banks: 576 (bank 1), 1152 (bank 0)
    send_cw(576, 576, 8'h10, 1'b0);
    send_cw(1152, 1152, 8'h20, 1'b0);
    chk("full_occ", 32'(o_occupancy), 32'd2);
    chk("full_ready", 32'(o_in_ready), 32'd0);
    chk("full_len", 32'(o_cw_len), 32'd576);
    rd("a_rd575", 575, 1'b1, 8'h4F);
    rd("a_rd576", 576, 1'b0, 0);

    // Third codeword stalls at sample 0
    i_in_valid = 1'b1;
    i_in_data  = 8'h40;
    i_cw_len   = LW'(8);
    tick();
    tick();
    tick();
    chk("stall_ready", 32'(o_in_ready), 32'd0);
    chk("stall_occ", 32'(o_occupancy), 32'd2);
    release_pulse();
    chk("unstall_ready", 32'(o_in_ready), 32'd1);
    chk("unstall_occ", 32'(o_occupancy), 32'd1);
    chk("unstall_len", 32'(o_cw_len), 32'd1152);
    send_cw(8, 8, 8'h40, 1'b0);
    chk("c_occ", 32'(o_occupancy), 32'd2);
    chk("c_ready", 32'(o_in_ready), 32'd0);
    rd("b_rd1151", 1151, 1'b1, 8'h9F);

    // Release B, then commit D with a simultaneous release of C
    release_pulse();
    chk("relb_occ", 32'(o_occupancy), 32'd1);
    chk("relb_len", 32'(o_cw_len), 32'd8);
    rd("c_rd7", 7, 1'b1, 8'h47);
    send_cw(4, 4, 8'h60, 1'b1);
    chk("cr_occ", 32'(o_occupancy), 32'd1);
    chk("cr_len", 32'(o_cw_len), 32'd4);
    rd("d_rd3", 3, 1'b1, 8'h63);
    rd("d_rd4", 4, 1'b0, 0);
    release_pulse();
    chk("reld_occ", 32'(o_occupancy), 32'd0);
    release_pulse();
    chk("empty_rel_occ", 32'(o_occupancy), 32'd0);
    chk("empty_rel_avail", 32'(o_cw_avail), 32'd0);
    chk("empty_rel_ready", 32'(o_in_ready), 32'd1);
    rd("empty_rd", 0, 1'b0, 0);

    // Illegal length 0: one error pulse, commit only after 2304 samples
    len_err_cnt = 0;
    send_cw(0, 2303, 0, 1'b0);
    chk("len0_no_commit", 32'(o_occupancy), 32'd0);
    send_cw(5, 1, 2303, 1'b0);
    chk("len0_err_pulses", 32'(len_err_cnt), 32'd1);
    chk("len0_occ", 32'(o_occupancy), 32'd1);
    chk("len0_len", 32'(o_cw_len), 32'd2304);
    rd("len0_rd2303", 2303, 1'b1, 8'hFF);
    release_pulse();

    // Illegal length 3000
    len_err_cnt = 0;
    send_cw(3000, 2303, 8'h80, 1'b0);
    chk("len3000_no_commit", 32'(o_occupancy), 32'd0);
    send_cw(3000, 1, 8'h80 + 2303, 1'b0);
    chk("len3000_err_pulses", 32'(len_err_cnt), 32'd1);
    chk("len3000_occ", 32'(o_occupancy), 32'd1);
    chk("len3000_len", 32'(o_cw_len), 32'd2304);
    rd("len3000_rd0", 0, 1'b1, 8'h80);

    // Reset mid-codeword with one committed bank
    send_cw(100, 10, 0, 1'b0);
    i_reset_n = 1'b0;
    #2;
    chk("mrst_in_ready", 32'(o_in_ready), 32'd0);
    chk("mrst_avail", 32'(o_cw_avail), 32'd0);
    chk("mrst_len", 32'(o_cw_len), 32'd0);
    chk("mrst_occ", 32'(o_occupancy), 32'd0);
    chk("mrst_rd_data", 32'(o_rd_data), 32'd0);
    tick();
    i_reset_n = 1'b1;
    tick();
    chk("mrst_ready_back", 32'(o_in_ready), 32'd1);
    send_cw(2304, 2304, 8'h33, 1'b0);
    chk("fresh_occ", 32'(o_occupancy), 32'd1);
    chk("fresh_len", 32'(o_cw_len), 32'd2304);
    rd("fresh_rd5", 5, 1'b1, 8'h38);
    rd("fresh_rd2303", 2303, 1'b1, 8'h32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ldpc_llr_buffer.md
# ldpc_llr_buffer

Multi-bank LLR input buffer for the LDPC decoder. It accepts a stream of soft-decision LLRs, packs each codeword into one of NUM_BANKS RAM banks, and presents committed codewords to the decoder core for random-access reads. Codeword length is selectable per codeword at run time, which supports all code rates and lifting sizes up to MAX_CW_LEN. Banks are freed by an explicit release from the decoder.

## Interface
- LLR_WIDTH, 8, bits per LLR sample
- MAX_CW_LEN, 2304, largest codeword length in samples
- NUM_BANKS, 2, codeword banks; power of 2, ≥2
- Derived: AW = $clog2(MAX_CW_LEN); LW = $clog2(MAX_CW_LEN+1); BW = $clog2(NUM_BANKS)

- i_clock  in  1  single clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_cw_len  in  LW  length of the next codeword; sampled on its first accepted sample
- i_in_data  in  LLR_WIDTH  LLR sample
- i_in_valid  in  1  sample valid
- o_in_ready  out  1  buffer can accept a sample (registered)
- o_cw_avail  out  1  at least one committed codeword is readable
- o_cw_len  out  LW  length of the codeword in the read bank
- i_rd_en  in  1  read request
- i_rd_addr  in  AW  sample index within the read bank
- o_rd_data  out  LLR_WIDTH  read data
- o_rd_valid  out  1  o_rd_data valid
- i_cw_release  in  1  one-cycle pulse; frees the read bank
- o_occupancy  out  BW+1  number of committed banks
- o_len_err  out  1  one-cycle pulse when an illegal i_cw_len is sampled

## Operation
- Storage is one simple-dual-port RAM with depth NUM_BANKS·2^AW. The address is {bank, index}.
- Write side:
  - A write occurs on i_in_valid & o_in_ready. Data goes to {wr_bank, wr_count}.
  - On the first sample of a codeword (wr_count==0), cur_len is latched from i_cw_len.
  - If i_cw_len is 0 or greater than MAX_CW_LEN, cur_len = MAX_CW_LEN and o_len_err pulses on the next cycle.
  - The sample that completes the codeword is the one accepted with wr_count==cur_len-1. On that sample:
    - the bank commits;
    - cur_len is stored in bank_len[wr_bank];
    - wr_bank wraps modulo NUM_BANKS;
    - wr_count is set to 0;
    - occupancy increments.
- Flow control: o_in_ready = (occupancy_next < NUM_BANKS). It is registered.
- Read side:
  - o_cw_avail = (occupancy != 0).
  - o_cw_len = bank_len[rd_bank] while o_cw_avail is high; otherwise 0.
  - A read is accepted when i_rd_en & o_cw_avail & (i_rd_addr < o_cw_len).
  - Any other i_rd_en is ignored: o_rd_valid stays 0.
- Release:
  - i_cw_release with o_cw_avail high: rd_bank wraps modulo NUM_BANKS and occupancy decrements.
  - Release while empty is ignored.
- Simultaneous commit and release: occupancy is unchanged and both pointers advance.
- Read and release in the same cycle: the read uses the pre-release rd_bank.
- A bank being read is never written, because occupancy < NUM_BANKS is required for writes.
- The empty-slot write bank and the read bank differ whenever occupancy > 0.

## Timing
- Reset values (async assert, sync release): o_in_ready, o_cw_avail, o_rd_valid and o_len_err are 0; o_cw_len, o_occupancy and o_rd_data are 0. All pointers, counts and bank_len entries are 0.
- o_in_ready rises on the first rising edge after i_reset_n deasserts.
- Read latency is 1 cycle: a request accepted at edge N gives o_rd_data and o_rd_valid=1 after edge N+1. The block supports a full-rate read every cycle with no backpressure.
- Commit to availability: o_cw_avail rises, and o_occupancy updates, the cycle after the last sample is accepted.
- Ready drop: o_in_ready falls the cycle after the commit that fills the last bank. No sample is accepted in that transition.
- Release to ready: o_in_ready rises the cycle after a release from full.
- Mid-codeword reset discards the partial codeword and all committed banks.
- The RAM contents are not cleared on reset. o_rd_data reflects RAM contents only when o_rd_valid=1.

## Test plan
- Reset, then stream 2304 samples (data = index mod 256) with i_cw_len=2304 → o_cw_avail=1 one cycle after the last sample, o_cw_len=2304, o_occupancy=1. Read addr 0,1,2303 → data 0x00, 0x01, 0xFF, each with 1-cycle latency.
- NUM_BANKS=2: stream three codewords with no release → o_in_ready=0 after the 2nd commit, the 3rd codeword stalls at sample 0, o_occupancy=2. Pulse i_cw_release → o_in_ready=1 next cycle and the 3rd codeword completes.
- Per-codeword length: i_cw_len=576, then 1152 → o_cw_len=576. Read addr 576 → o_rd_valid stays 0. After release, o_cw_len=1152.
- Illegal length: i_cw_len=0 on the first sample → o_len_err pulses once and the codeword commits after 2304 samples. Repeat with i_cw_len=3000 and expect the same result.
- Commit and release in the same cycle with occupancy=1 → o_occupancy stays 1, rd_bank advances, and o_cw_len shows the new bank. Release while empty → no change.
- Assert i_reset_n=0 mid-codeword with occupancy=1 → all outputs 0 immediately. After release, a fresh 2304-sample codeword commits into bank 0.
